// File: rtl/iter_shift_ext_unit.sv
// Multi-cycle shift/rotate unit (STEP bits per cycle) with a registered immediate extender.
// Optional define SHIFT_STICKY_EN builds the shifted-out sticky accumulator; otherwise Sticky is 0.
module iter_shift_ext_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 5,
  parameter int unsigned STEP  = 1,
  parameter int unsigned IMM_W = 12
) (
  input  logic             CLK,
  input  logic             RstN,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] ShiftIn,
  input  logic [AMT_W-1:0] Amt,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic [IMM_W-1:0] Imm,
  input  logic             ImmSel,
  input  logic             ExtLoad,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] ShiftOut,
  output logic [WIDTH-1:0] ExtOut,
  output logic             Sticky
);

  localparam logic [AMT_W-1:0] WIDTH_A    = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_A     = AMT_W'(STEP);
  localparam logic [1:0]       MODE_ARITH = 2'b01;
  localparam logic [1:0]       MODE_ROT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] shift_out_q, shift_out_d;
  logic [WIDTH-1:0] ext_out_q, ext_out_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [AMT_W-1:0] eff_amt_c;
  logic [AMT_W-1:0] step_c;
  logic [WIDTH-1:0] shifted_c;
  logic             accept_c;
  logic             shift_c;
  logic             fin_c;

  // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH
  always_comb begin
    if (Mode == MODE_ROT) begin
      eff_amt_c = Amt % WIDTH_A;
    end else if (Amt > WIDTH_A) begin
      eff_amt_c = WIDTH_A;
    end else begin
      eff_amt_c = Amt;
    end
  end

  // One iteration of the shifter: moves min(STEP, rem) bits
  always_comb begin
    step_c = (rem_q < STEP_A) ? rem_q : STEP_A;
    if (mode_q == MODE_ROT) begin
      if (dir_q) begin
        shifted_c = (work_q >> step_c) | (work_q << (WIDTH_A - step_c));
      end else begin
        shifted_c = (work_q << step_c) | (work_q >> (WIDTH_A - step_c));
      end
    end else if (dir_q && (mode_q == MODE_ARITH)) begin
      shifted_c = $signed(work_q) >>> step_c;
    end else if (dir_q) begin
      shifted_c = work_q >> step_c;
    end else begin
      shifted_c = work_q << step_c;
    end
  end

  assign accept_c = (state_q == S_IDLE) && Start;
  assign shift_c  = (state_q == S_SHIFT) && !Abort;
  assign fin_c    = shift_c && (rem_q == step_c);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    shift_out_d = shift_out_q;
    ext_out_d   = ext_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          work_d = ShiftIn;
          dir_d  = Dir;
          mode_d = Mode;
          rem_d  = eff_amt_c;
          if (eff_amt_c == '0) begin
            state_d     = S_DONE;
            shift_out_d = ShiftIn;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          work_d = shifted_c;
          rem_d  = rem_q - step_c;
          if (fin_c) begin
            state_d     = S_DONE;
            shift_out_d = shifted_c;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ExtLoad) begin
      ext_out_d = ImmSel ? WIDTH'($signed(Imm)) : WIDTH'(Imm);
    end

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RstN) begin
    if (!RstN) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
      shift_out_q <= '0;
      ext_out_q   <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      shift_out_q <= shift_out_d;
      ext_out_q   <= ext_out_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign Ready    = ready_q;
  assign Done     = done_q;
  assign ShiftOut = shift_out_q;
  assign ExtOut   = ext_out_q;

`ifdef SHIFT_STICKY_EN
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] out_bits_c;
  logic             acc_q, acc_d;
  logic             sticky_q, sticky_d;

  // Accumulator runs during the shift; Sticky publishes it alongside ShiftOut
  always_comb begin
    out_bits_c = dir_q ? (work_q & ~(ONES << step_c)) : (work_q & ~(ONES >> step_c));
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    if (accept_c) begin
      acc_d = 1'b0;
      if (eff_amt_c == '0) begin
        sticky_d = 1'b0;
      end
    end else if (shift_c) begin
      if (mode_q != MODE_ROT) begin
        acc_d = acc_q | (|out_bits_c);
      end
      if (fin_c) begin
        sticky_d = acc_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge RstN) begin
    if (!RstN) begin
      acc_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign Sticky = sticky_q;
`else
  assign Sticky = 1'b0;
`endif

endmodule

// File: tb/tb_iter_shift_ext_unit.sv
// Bench for iter_shift_ext_unit: STEP=1 and STEP=3 instances share stimulus; results checked
// against a table of known vectors and a word-level reference model on random operations.
module tb_iter_shift_ext_unit;

  logic        CLK = 1'b0;
  logic        RstN = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] ShiftIn = '0;
  logic [4:0]  Amt = '0;
  logic        Dir = 1'b0;
  logic [1:0]  Mode = '0;
  logic [11:0] Imm = '0;
  logic        ImmSel = 1'b0;
  logic        ExtLoad = 1'b0;

  logic        ready1, done1, st1, ready3, done3, st3;
  logic [15:0] so1, eo1, so3, eo3;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  iter_shift_ext_unit #(.WIDTH(16), .AMT_W(5), .STEP(1), .IMM_W(12)) u_dut1 (
    .CLK(CLK), .RstN(RstN), .Start(Start), .Abort(Abort), .ShiftIn(ShiftIn), .Amt(Amt),
    .Dir(Dir), .Mode(Mode), .Imm(Imm), .ImmSel(ImmSel), .ExtLoad(ExtLoad),
    .Ready(ready1), .Done(done1), .ShiftOut(so1), .ExtOut(eo1), .Sticky(st1));

  iter_shift_ext_unit #(.WIDTH(16), .AMT_W(5), .STEP(3), .IMM_W(12)) u_dut3 (
    .CLK(CLK), .RstN(RstN), .Start(Start), .Abort(Abort), .ShiftIn(ShiftIn), .Amt(Amt),
    .Dir(Dir), .Mode(Mode), .Imm(Imm), .ImmSel(ImmSel), .ExtLoad(ExtLoad),
    .Ready(ready3), .Done(done3), .ShiftOut(so3), .ExtOut(eo3), .Sticky(st3));

  typedef struct {
    logic [15:0] x;
    logic [4:0]  amt;
    logic        dir;
    logic [1:0]  mode;
    logic [15:0] res;
    int          lat1;
    int          lat3;
    logic        st;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Word-level reference: double-width concatenations instead of per-bit iteration
  function automatic void model(input logic [15:0] x, input int amt, input logic dir,
                                input logic [1:0] mode, output logic [15:0] res,
                                output logic st, output int e);
    logic [31:0] d;
    logic [47:0] t;
    st = 1'b0;
    if (mode == 2'b10) begin
      e = amt % 16;
      d = {x, x};
      d = dir ? (d >> e) : (d >> (16 - e));
      res = d[15:0];
    end else begin
      e = (amt > 16) ? 16 : amt;
      if (!dir) begin
        d   = {16'h0000, x} << e;
        res = d[15:0];
        st  = |d[31:16];
      end else begin
        t   = {((mode == 2'b01 && x[15]) ? 16'hFFFF : 16'h0000), x, 16'h0000} >> e;
        res = t[31:16];
        st  = |t[15:0];
      end
    end
  endfunction

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (ready1 && ready3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", {31'b0, ready1 & ready3}, 32'd1);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int          lat1 = -1;
    int          lat3 = -1;
    logic [15:0] r1 = '0;
    logic [15:0] r3 = '0;
    logic        s1 = 1'b0;
    logic        s3 = 1'b0;
    logic        exp_st;
    wait_idle();
    ShiftIn = v.x; Amt = v.amt; Dir = v.dir; Mode = v.mode; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (done1 && lat1 < 0) begin lat1 = n; r1 = so1; s1 = st1; end
      if (done3 && lat3 < 0) begin lat3 = n; r3 = so3; s3 = st3; end
      if (lat1 >= 0 && lat3 >= 0) break;
    end
`ifdef SHIFT_STICKY_EN
    exp_st = v.st;
`else
    exp_st = 1'b0;
`endif
    chk({tag, " lat_s1"}, lat1, v.lat1);
    chk({tag, " res_s1"}, {16'b0, r1}, {16'b0, v.res});
    chk({tag, " sticky_s1"}, {31'b0, s1}, {31'b0, exp_st});
    chk({tag, " lat_s3"}, lat3, v.lat3);
    chk({tag, " res_s3"}, {16'b0, r3}, {16'b0, v.res});
    chk({tag, " sticky_s3"}, {31'b0, s3}, {31'b0, exp_st});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [15:0] mres;
    logic        mst;
    int          me;
    int          pulses;
    int          first;

    tbl[0]  = '{16'h00F1, 5'd4,  1'b0, 2'd0, 16'h0F10, 4,  2, 1'b0};
    tbl[1]  = '{16'h8000, 5'd20, 1'b1, 2'd1, 16'hFFFF, 16, 6, 1'b1};
    tbl[2]  = '{16'h8000, 5'd20, 1'b1, 2'd0, 16'h0000, 16, 6, 1'b1};
    tbl[3]  = '{16'h1234, 5'd20, 1'b1, 2'd2, 16'h4123, 4,  2, 1'b0};
    tbl[4]  = '{16'h1234, 5'd16, 1'b0, 2'd2, 16'h1234, 0,  0, 1'b0};
    tbl[5]  = '{16'h0013, 5'd2,  1'b1, 2'd0, 16'h0004, 2,  1, 1'b1};
    tbl[6]  = '{16'h0010, 5'd2,  1'b1, 2'd0, 16'h0004, 2,  1, 1'b0};
    tbl[7]  = '{16'h8001, 5'd1,  1'b0, 2'd3, 16'h0002, 1,  1, 1'b1};
    tbl[8]  = '{16'hC001, 5'd3,  1'b0, 2'd1, 16'h0008, 3,  1, 1'b1};
    tbl[9]  = '{16'hABCD, 5'd0,  1'b1, 2'd0, 16'hABCD, 0,  0, 1'b0};
    tbl[10] = '{16'h8001, 5'd31, 1'b0, 2'd2, 16'hC000, 15, 5, 1'b0};
    tbl[11] = '{16'h0F0F, 5'd5,  1'b1, 2'd1, 16'h0078, 5,  2, 1'b1};
    tbl[12] = '{16'hF000, 5'd16, 1'b0, 2'd0, 16'h0000, 16, 6, 1'b1};

    // Reset values
    #12;
    chk("rst ready", {31'b0, ready1}, 32'd1);
    chk("rst done", {31'b0, done1}, 32'd0);
    chk("rst shiftout", {16'b0, so1}, 32'd0);
    chk("rst extout", {16'b0, eo1}, 32'd0);
    chk("rst sticky", {31'b0, st1}, 32'd0);
    @(negedge CLK);
    RstN = 1'b1;

    // Immediate extension
    @(negedge CLK);
    Imm = 12'h8A5; ImmSel = 1'b1; ExtLoad = 1'b1;
    @(negedge CLK);
    chk("ext sign", {16'b0, eo1}, 32'h0000F8A5);
    ImmSel = 1'b0;
    @(negedge CLK);
    chk("ext zero", {16'b0, eo1}, 32'h000008A5);
    ExtLoad = 1'b0; Imm = 12'hF23; ImmSel = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("ext hold", {16'b0, eo1}, 32'h000008A5);

    for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 24; i++) begin
      v.x    = 16'($urandom);
      v.amt  = 5'($urandom_range(0, 31));
      v.dir  = 1'($urandom_range(0, 1));
      v.mode = 2'($urandom_range(0, 3));
      model(v.x, int'(v.amt), v.dir, v.mode, mres, mst, me);
      v.res  = mres;
      v.st   = mst;
      v.lat1 = me;
      v.lat3 = (me + 2) / 3;
      run_op(v, $sformatf("rnd%0d", i));
    end

    // Start held through the whole shift: exactly one Done
    wait_idle();
    ShiftIn = 16'h0001; Amt = 5'd8; Dir = 1'b0; Mode = 2'd0; Start = 1'b1;
    @(posedge CLK);
    pulses = 0;
    first  = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (n == 3) chk("held ready_low", {31'b0, ready1}, 32'd0);
      if (done1) begin
        pulses++;
        if (first < 0) first = n;
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    chk("held pulses", pulses, 32'd1);
    chk("held lat", first, 32'd8);
    chk("held res", {16'b0, so1}, 32'h00000100);
    wait_idle();
    wait_idle();

    // Abort on the second shift edge of an Amt=8 shift
    ShiftIn = 16'hFFFF; Amt = 5'd8; Dir = 1'b0; Mode = 2'd0; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    @(posedge CLK);
    #1 Abort = 1'b1;
    @(posedge CLK);
    #1 Abort = 1'b0;
    @(negedge CLK);
    chk("abort ready1", {31'b0, ready1}, 32'd1);
    chk("abort ready3", {31'b0, ready3}, 32'd1);
    chk("abort done1", {31'b0, done1}, 32'd0);
    chk("abort hold1", {16'b0, so1}, 32'h00000100);
    chk("abort hold3", {16'b0, so3}, 32'h00000100);
    chk("abort sticky1", {31'b0, st1}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (done1 || done3) pulses++;
    end
    chk("abort no_done", pulses, 32'd0);

    // Asynchronous reset in the middle of a shift
    wait_idle();
    ShiftIn = 16'h00F1; Amt = 5'd8; Dir = 1'b0; Mode = 2'd0; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RstN = 1'b0;
    #1;
    chk("midrst ready", {31'b0, ready1}, 32'd1);
    chk("midrst done", {31'b0, done1}, 32'd0);
    chk("midrst shiftout", {16'b0, so1}, 32'd0);
    chk("midrst extout", {16'b0, eo1}, 32'd0);
    chk("midrst ready3", {31'b0, ready3}, 32'd1);
    @(negedge CLK);
    RstN = 1'b1;
    run_op(tbl[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
